pc_stack_counter: RTL

Parametrised program counter for the 8-bit CPU: a WIDTH-bit counter with load, increment, signed relative branch and an optional hardware return-address stack (RAS) for call/return. It drives the shared bus through a registered output-enable and exposes the raw count for the control sequencer. It is the next-generation replacement for the fixed 4-bit JK-based counter.

---
 rtl/pc_stack_counter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pc_stack_counter.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_counter
// Description : WIDTH-bit program counter with load, increment, signed
//               relative branch, registered bus output enable and an
//               optional hardware return-address stack for call/return.
//               Define PC_RAS_EN to build the return-address stack; without
//               it call acts as load and ret acts as no command.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stack_counter #(
    parameter int               WIDTH     = 4,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load,
    input  logic             rel,
    input  logic             cp,
    input  logic             call,
    input  logic             ret,
    input  logic             ep,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic [WIDTH-1:0] pc,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err
);

    logic [WIDTH-1:0] r_pc;
    logic             r_bus_oe;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_inc;

    // pc+1 is shared by the count command and the pushed return address
    assign w_pc_inc = r_pc + WIDTH'(1);

`ifdef PC_RAS_EN
    // Stack pointer must represent 0..RAS_DEPTH inclusive
    localparam int              c_SPW     = $clog2(RAS_DEPTH + 1);
    localparam int              c_IDXW    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [c_SPW-1:0] c_SP_FULL = c_SPW'(RAS_DEPTH);

    logic [WIDTH-1:0]  r_stack [RAS_DEPTH];
    logic [c_SPW-1:0]  r_sp;
    logic              r_err;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_err_set;
    logic [c_SPW-1:0]  w_sp_dec;
    logic [c_IDXW-1:0] w_push_idx;
    logic [c_IDXW-1:0] w_pop_idx;

    assign w_full     = (r_sp == c_SP_FULL);
    assign w_empty    = (r_sp == '0);
    assign w_sp_dec   = r_sp - c_SPW'(1);
    assign w_push_idx = r_sp[c_IDXW-1:0];
    assign w_pop_idx  = w_sp_dec[c_IDXW-1:0];

    // Command decode with priority ret > call > load > rel > cp
    always_comb begin
        w_pc_next = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        if (ret) begin
            if (w_empty) begin
                w_err_set = 1'b1;
            end else begin
                w_pc_next = r_stack[w_pop_idx];
                w_pop     = 1'b1;
            end
        end else if (call) begin
            // The jump is taken even when the push is refused
            w_pc_next = d_in;
            if (w_full) begin
                w_err_set = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end else if (load) begin
            w_pc_next = d_in;
        end else if (rel) begin
            // Modulo add of the raw offset equals adding its sign extension
            w_pc_next = r_pc + d_in;
        end else if (cp) begin
            w_pc_next = w_pc_inc;
        end
    end

    // Stack storage is deliberately not reset; only the pointer is
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    // Stack pointer and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_sp <= r_sp + c_SPW'(1);
            end else if (w_pop) begin
                r_sp <= w_sp_dec;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ras_full  = w_full;
    assign ras_empty = w_empty;
    assign ras_err   = r_err;
`else
    // Command decode: ret is a no-op that still blocks lower priorities
    always_comb begin
        w_pc_next = r_pc;
        if (ret) begin
            w_pc_next = r_pc;
        end else if (call || load) begin
            w_pc_next = d_in;
        end else if (rel) begin
            w_pc_next = r_pc + d_in;
        end else if (cp) begin
            w_pc_next = w_pc_inc;
        end
    end

    assign ras_full  = 1'b0;
    assign ras_empty = 1'b1;
    assign ras_err   = 1'b0;
`endif

    // Program counter and registered bus enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_VEC;
            r_bus_oe <= 1'b0;
        end else begin
            r_pc     <= w_pc_next;
            r_bus_oe <= ep;
        end
    end

    assign pc      = r_pc;
    assign bus_oe  = r_bus_oe;
    assign bus_out = r_bus_oe ? r_pc : '0;

endmodule
`default_nettype wire
